// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: merges jump, divide, fetch-wait and load-use
// requests into one consistent strobe set, with statistics and a fetch-wait watchdog.
module pipe_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int FLUSH_CYC = 2,
    parameter int WDOG_MAX  = 1023
) (
    input  logic              clk_100MHz,
    input  logic              rst,
    input  logic              jump_req_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              div_busy_i,
    input  logic              load_use_i,
    input  logic              bus_wait_i,
    output logic              pc_jump_ena_o,
    output logic [ADDR_W-1:0] pc_jump_addr_o,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              hold_id_ex_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              div_cancel_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o,
    output logic              wdog_trip_o,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    localparam int FL_W = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLUSH_CYC - 1);
    localparam int WD_W = $clog2(WDOG_MAX + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_MAX);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_MAX - 1);

    state_t            state;
    logic [FL_W-1:0]   flush_left;
    logic [WD_W-1:0]   wdog_cnt;
    logic              any_hold;

    assign fsm_state = state;
    assign any_hold  = hold_pc_o | hold_if_id_o | hold_id_ex_o;

    // Priority jump > flush tail > div_busy > bus_wait > load_use; all quiet in reset.
    always_comb begin
        pc_jump_ena_o  = 1'b0;
        pc_jump_addr_o = '0;
        hold_pc_o      = 1'b0;
        hold_if_id_o   = 1'b0;
        hold_id_ex_o   = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        div_cancel_o   = 1'b0;
        if (!rst) begin
            if (jump_req_i) begin
                pc_jump_ena_o  = 1'b1;
                pc_jump_addr_o = jump_addr_i;
                flush_if_id_o  = 1'b1;
                flush_id_ex_o  = 1'b1;
                div_cancel_o   = div_busy_i;
            end else if (state == FLUSH) begin
                flush_if_id_o  = 1'b1;
                flush_id_ex_o  = 1'b1;
            end else if (div_busy_i) begin
                hold_pc_o      = 1'b1;
                hold_if_id_o   = 1'b1;
                hold_id_ex_o   = 1'b1;
            end else if (bus_wait_i) begin
                hold_pc_o      = 1'b1;
                flush_if_id_o  = 1'b1;
            end else if (load_use_i) begin
                hold_pc_o      = 1'b1;
                hold_if_id_o   = 1'b1;
                flush_id_ex_o  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state       <= RUN;
            flush_left  <= '0;
            wdog_cnt    <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            wdog_trip_o <= 1'b0;
        end else begin
            if (jump_req_i) begin
                flush_left <= FL_LOAD;
                state      <= (FL_LOAD != '0) ? FLUSH : RUN;
                if (flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 32'd1;
            end else begin
                case (state)
                    FLUSH: begin
                        flush_left <= flush_left - FL_W'(1);
                        state      <= (flush_left == FL_W'(1)) ? RUN : FLUSH;
                    end
                    default: state <= div_busy_i ? DIV_WAIT : RUN;
                endcase
            end

            if (any_hold && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;

            // The trip flag rises together with wdog_cnt reaching WDOG_MAX.
            if (bus_wait_i) begin
                if (wdog_cnt != WD_MAX) wdog_cnt <= wdog_cnt + WD_W'(1);
                if (wdog_cnt >= WD_LAST) wdog_trip_o <= 1'b1;
            end else begin
                wdog_cnt <= '0;
            end
        end
    end

endmodule
